// File: rtl/bus_slave_regs.sv
// bus_slave_regs: responder end of the shared system bus with a 16-word register bank.
//   Registers 0..14 are read/write, and register 15 returns ID_VALUE (writes to it are dropped).
//   The response is WAIT_CYCLES+1 cycles after the strobe.
//   Strobes that arrive while a transfer is in flight are ignored.
//   Dropping cs during the wait states aborts the transfer, with no rdy and no write.
// Ports:
//   clk      - rising-edge clock
//   reset_   - asynchronous active-low reset
//   cs       - chip select from the address decoder
//   as       - one-cycle request strobe
//   rw       - direction, 1 = read, sampled with as
//   addr     - word address, sampled with as
//   wr_data  - write data, sampled with as
//   rd_data  - read data, zero unless rdy is high
//   rdy      - one-cycle completion strobe
// Both rd_data and rdy are registered, so there is no combinational path from the bus inputs.
module bus_slave_regs #(
   parameter int          WAIT_CYCLES = 1,
   parameter logic [31:0] ID_VALUE    = 32'h4C49_5400
) (
   input  logic        clk,
   input  logic        reset_,
   input  logic        cs,
   input  logic        as,
   input  logic        rw,
   input  logic [3:0]  addr,
   input  logic [31:0] wr_data,
   output logic [31:0] rd_data,
   output logic        rdy
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   localparam logic [3:0] RO_ADDR = 4'd15;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        rw_q, rw_d;
   logic [3:0]  addr_q, addr_d;
   logic [31:0] wdat_q, wdat_d;
   logic        rdy_q, rdy_d;
   logic [31:0] rd_data_q, rd_data_d;
   // Entry 15 is never written; its read is replaced by ID_VALUE.
   logic [31:0] regs_q [16];
   logic [31:0] regs_d [16];

   function automatic logic [31:0] read_word(input logic [3:0] a);
      if (a == RO_ADDR) begin
         return ID_VALUE;
      end
      return regs_q[a];
   endfunction

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rw_d      = rw_q;
      addr_d    = addr_q;
      wdat_d    = wdat_q;
      rdy_d     = 1'b0;
      rd_data_d = 32'h0;
      regs_d    = regs_q;

      case (state_q)
         ST_IDLE: begin
            if (cs && as) begin
               rw_d   = rw;
               addr_d = addr;
               wdat_d = wr_data;
               cnt_d  = 4'(WAIT_CYCLES);
               if (WAIT_CYCLES == 0) begin
                  // No wait states: the response flops are loaded on the accept edge.
                  state_d   = ST_RESP;
                  rdy_d     = 1'b1;
                  rd_data_d = rw ? read_word(addr) : 32'h0;
               end else begin
                  state_d = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            if (!cs) begin
               // Abort: nothing was committed, so simply drop the transfer.
               state_d = ST_IDLE;
               cnt_d   = 4'd0;
            end else if (cnt_q <= 4'd1) begin
               // rdy/rd_data are registered, so they are loaded on the edge entering RESP.
               state_d   = ST_RESP;
               cnt_d     = 4'd0;
               rdy_d     = 1'b1;
               rd_data_d = rw_q ? read_word(addr_q) : 32'h0;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_RESP: begin
            // A write commits on the edge that ends the rdy cycle.
            if (!rw_q && (addr_q != RO_ADDR)) begin
               regs_d[addr_q] = wdat_q;
            end
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         state_q   <= ST_IDLE;
         cnt_q     <= 4'd0;
         rw_q      <= 1'b0;
         addr_q    <= 4'd0;
         wdat_q    <= 32'h0;
         rdy_q     <= 1'b0;
         rd_data_q <= 32'h0;
         for (int i = 0; i < 16; i++) begin
            regs_q[i] <= 32'h0;
         end
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rw_q      <= rw_d;
         addr_q    <= addr_d;
         wdat_q    <= wdat_d;
         rdy_q     <= rdy_d;
         rd_data_q <= rd_data_d;
         regs_q    <= regs_d;
      end
   end

   assign rdy     = rdy_q;
   assign rd_data = rd_data_q;

endmodule

// File: tb/tb_bus_slave_regs.sv
// tb_bus_slave_regs: directed bench for bus_slave_regs.
//   Four instances use WAIT_CYCLES = 0, 1, 3 and 15.
//   All instances share the request bus; each instance has its own chip select.
module tb_bus_slave_regs;

   localparam logic [31:0] ID = 32'h4C49_5400;

   logic        clk = 1'b0;
   logic        reset_;
   logic        as;
   logic        rw;
   logic [3:0]  addr;
   logic [31:0] wr_data;
   logic        cs0, cs1, cs3, cs15;
   logic        rdy0, rdy1, rdy3, rdy15;
   logic [31:0] rd0, rd1, rd3, rd15;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   bus_slave_regs #(.WAIT_CYCLES(0)) u_wc0 (
      .clk(clk), .reset_(reset_), .cs(cs0), .as(as), .rw(rw), .addr(addr),
      .wr_data(wr_data), .rd_data(rd0), .rdy(rdy0));
   bus_slave_regs #(.WAIT_CYCLES(1)) u_wc1 (
      .clk(clk), .reset_(reset_), .cs(cs1), .as(as), .rw(rw), .addr(addr),
      .wr_data(wr_data), .rd_data(rd1), .rdy(rdy1));
   bus_slave_regs #(.WAIT_CYCLES(3)) u_wc3 (
      .clk(clk), .reset_(reset_), .cs(cs3), .as(as), .rw(rw), .addr(addr),
      .wr_data(wr_data), .rd_data(rd3), .rdy(rdy3));
   bus_slave_regs #(.WAIT_CYCLES(15)) u_wc15 (
      .clk(clk), .reset_(reset_), .cs(cs15), .as(as), .rw(rw), .addr(addr),
      .wr_data(wr_data), .rd_data(rd15), .rdy(rdy15));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic sel_rdy(input int w);
      case (w)
         0:       return rdy0;
         1:       return rdy1;
         3:       return rdy3;
         default: return rdy15;
      endcase
   endfunction

   function automatic logic [31:0] sel_dat(input int w);
      case (w)
         0:       return rd0;
         1:       return rd1;
         3:       return rd3;
         default: return rd15;
      endcase
   endfunction

   task automatic set_cs(input int w, input logic v);
      case (w)
         0:       cs0 = v;
         1:       cs1 = v;
         3:       cs3 = v;
         default: cs15 = v;
      endcase
   endtask

   // Issue one request in cycle N and watch cycles N+1 .. N+lat+3.
   // Expected: rdy only in cycle N+lat, carrying exp_d, and rd_data zero in every other cycle.
   // When extra_as is set, a second (write) strobe is held during cycle N+1; it must be ignored.
   task automatic xfer(input int w, input logic r, input logic [3:0] a, input logic [31:0] d,
                       input int lat, input logic [31:0] exp_d, input bit extra_as,
                       input string tag);
      int          first = -1;
      int          nrdy  = 0;
      int          nz    = 0;
      logic [31:0] got   = 32'h0;
      set_cs(w, 1'b1);
      as = 1'b1; rw = r; addr = a; wr_data = d;
      @(posedge clk); #1;
      if (extra_as) begin
         rw = 1'b0; addr = 4'd3; wr_data = 32'h0;
      end else begin
         as = 1'b0;
      end
      for (int k = 1; k <= lat + 3; k++) begin
         @(negedge clk);
         if (sel_rdy(w)) begin
            nrdy++;
            if (first < 0) begin
               first = k;
               got   = sel_dat(w);
            end
         end else if (sel_dat(w) != 32'h0) begin
            nz++;
         end
         if (extra_as && k == 1) begin
            @(posedge clk); #1;
            as = 1'b0;
         end
      end
      @(posedge clk); #1;
      set_cs(w, 1'b0);
      chk({tag, " lat"},   32'(first), 32'(lat));
      chk({tag, " nrdy"},  32'(nrdy),  32'd1);
      chk({tag, " data"},  got,        exp_d);
      chk({tag, " idle0"}, 32'(nz),    32'd0);
   endtask

   // Count rdy pulses on instance w over n cycles, sampled on falling edges.
   task automatic count_rdy(input int w, input int n, output int cnt);
      cnt = 0;
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         if (sel_rdy(w)) cnt++;
      end
   endtask

   initial begin
      int c;
      reset_ = 1'b0; as = 1'b0; rw = 1'b0; addr = 4'd0; wr_data = 32'h0;
      cs0 = 1'b0; cs1 = 1'b0; cs3 = 1'b0; cs15 = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset rdy", 32'(rdy1), 32'd0);
      chk("reset rd_data", rd1, 32'h0);
      reset_ = 1'b1;
      @(posedge clk); #1;

      // After reset, registers 0..14 read as zero and register 15 reads as ID.
      for (int i = 0; i < 15; i++) begin
         xfer(1, 1'b1, 4'(i), 32'h0, 2, 32'h0, 1'b0, $sformatf("rst_rd%0d", i));
      end
      xfer(1, 1'b1, 4'd15, 32'h0, 2, ID, 1'b0, "rst_rd15");

      // Write followed by a readback of the same register.
      xfer(1, 1'b0, 4'd3, 32'hDEAD_BEEF, 2, 32'h0, 1'b0, "wr3");
      xfer(1, 1'b1, 4'd3, 32'h0, 2, 32'hDEAD_BEEF, 1'b0, "rd3");

      // Response latency for each wait-state setting.
      xfer(0, 1'b1, 4'd0, 32'h0, 1, 32'h0, 1'b0, "wc0_rd0");
      xfer(1, 1'b1, 4'd0, 32'h0, 2, 32'h0, 1'b0, "wc1_rd0");
      xfer(15, 1'b1, 4'd0, 32'h0, 16, 32'h0, 1'b0, "wc15_rd0");
      xfer(0, 1'b0, 4'd7, 32'h0BAD_CAFE, 1, 32'h0, 1'b0, "wc0_wr7");
      xfer(0, 1'b1, 4'd7, 32'h0, 1, 32'h0BAD_CAFE, 1'b0, "wc0_rd7");

      // Abort: dropping cs during the wait states gives no rdy and no write.
      cs3 = 1'b1; as = 1'b1; rw = 1'b0; addr = 4'd5; wr_data = 32'h1234_5678;
      @(posedge clk); #1;
      as = 1'b0; cs3 = 1'b0;
      count_rdy(3, 8, c);
      chk("abort nrdy", 32'(c), 32'd0);
      @(posedge clk); #1;
      xfer(3, 1'b1, 4'd5, 32'h0, 4, 32'h0, 1'b0, "abort_rd5");

      // A second strobe during WAIT is ignored (it must not clobber reg 3).
      // Register 15 is read-only.
      xfer(1, 1'b1, 4'd15, 32'h0, 2, ID, 1'b1, "dup_as_rd15");
      xfer(1, 1'b1, 4'd3, 32'h0, 2, 32'hDEAD_BEEF, 1'b0, "dup_as_rd3");
      xfer(1, 1'b0, 4'd15, 32'hFFFF_FFFF, 2, 32'h0, 1'b0, "wr15");
      xfer(1, 1'b1, 4'd15, 32'h0, 2, ID, 1'b0, "ro_rd15");

      // Async reset during RESP clears rdy and rd_data without a clock edge.
      cs1 = 1'b1; as = 1'b1; rw = 1'b1; addr = 4'd15;
      @(posedge clk); #1;
      as = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("pre_rst rdy", 32'(rdy1), 32'd1);
      chk("pre_rst rd_data", rd1, ID);
      #1 reset_ = 1'b0;
      #1;
      chk("async_rst rdy", 32'(rdy1), 32'd0);
      chk("async_rst rd_data", rd1, 32'h0);
      @(negedge clk);
      reset_ = 1'b1;
      count_rdy(1, 5, c);
      chk("post_rst1 nrdy", 32'(c), 32'd0);
      @(posedge clk); #1;
      cs1 = 1'b0;

      // Async reset during WAIT aborts the read and clears the bank.
      xfer(1, 1'b0, 4'd3, 32'hA5A5_A5A5, 2, 32'h0, 1'b0, "wr3b");
      cs1 = 1'b1; as = 1'b1; rw = 1'b1; addr = 4'd3;
      @(posedge clk); #1;
      as = 1'b0;
      @(negedge clk);
      chk("wait rdy", 32'(rdy1), 32'd0);
      #1 reset_ = 1'b0;
      #1;
      chk("wait_rst rdy", 32'(rdy1), 32'd0);
      chk("wait_rst rd_data", rd1, 32'h0);
      @(negedge clk);
      reset_ = 1'b1;
      count_rdy(1, 5, c);
      chk("post_rst2 nrdy", 32'(c), 32'd0);
      @(posedge clk); #1;
      cs1 = 1'b0;
      xfer(1, 1'b1, 4'd3, 32'h0, 2, 32'h0, 1'b0, "post_rst_rd3");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/bus_slave_regs.md
# bus_slave_regs

Generic bus slave with a 16-word register bank and a programmable number of wait states. It is the responder end of the shared system bus: it decodes a master's request (cs/as/rw/addr/wr_data) and returns the `rd_data`/`rdy` pair that feeds one `sN_*` input of the slave-side response mux. It is the template for peripheral register files and the bench slave for bus-level tests.

## Interface
- `WAIT_CYCLES`, 1: wait states inserted before `rdy`; legal range 0..15.
- `ID_VALUE`, 32'h4C49_5400: constant returned by read-only register 15.
- `clk` input 1: single clock; all state changes on the rising edge.
- `reset_` input 1: asynchronous, active-low reset.
- `cs` input 1: chip select from the address decoder, active-high (`ENABLE`).
- `as` input 1: address strobe, active-high; a one-cycle pulse marks a new request.
- `rw` input 1: 1 = read, 0 = write; sampled with `as`.
- `addr` input 4: word address 0..15; sampled with `as`.
- `wr_data` input `WORD_DATA` (32): write data; sampled with `as`.
- `rd_data` output `WORD_DATA` (32): read data, valid only while `rdy` is high; otherwise 32'h0.
- `rdy` output 1: response strobe, high for exactly one cycle per completed transfer.

## Operation
- Storage: registers 0..14 are 32-bit read/write. Register 15 is read-only and returns `ID_VALUE`. Writes to register 15 complete normally with `rdy`, but the write is discarded.
- States:
  - IDLE: accepts a request.
  - WAIT: counts wait states.
  - RESP: drives the response.
- IDLE: on a rising edge with `cs`=1 and `as`=1, latch `rw`, `addr` and `wr_data`, and load the wait counter with `WAIT_CYCLES`.
  - Next state is WAIT if `WAIT_CYCLES`>0, else RESP.
  - `as` without `cs` is ignored.
- WAIT: the counter decrements each cycle and moves to RESP when it reaches 1.
  - If `cs` drops to 0 in WAIT, the transfer aborts: return to IDLE, perform no write, never assert `rdy`.
- RESP:
  - `rdy`=1 for one cycle.
  - A read drives the latched register onto `rd_data`.
  - A write commits `wr_data` to the register on the edge that ends the RESP cycle; `rd_data` stays 0 for writes.
  - Next state is always IDLE.
- Requests arriving while in WAIT or RESP (`as`=1) are ignored, not queued. The master must wait for `rdy` before issuing the next strobe.
- The read value is taken from the register at the RESP cycle. A read can never observe its own pending write, because only one transfer is in flight.
- Reset (asynchronous, `reset_`=0):
  - State goes to IDLE.
  - `rdy`=0 and `rd_data`=0 immediately.
  - Wait counter = 0.
  - Registers 0..14 = 32'h0.
- Reset mid-transfer aborts the transfer with no write. Operation resumes on the first rising edge after `reset_` deasserts.

## Timing
- Request sampled at the rising edge ending cycle N. `rdy` is high in cycle N+1+`WAIT_CYCLES`.
  - Default `WAIT_CYCLES`=1: `rdy` in cycle N+2.
  - `WAIT_CYCLES`=0: `rdy` in cycle N+1.
- The write takes effect at the edge ending the `rdy` cycle. A read issued in the following cycle returns the new value.
- Minimum request spacing is `WAIT_CYCLES`+2 cycles. The earliest next strobe is the cycle after `rdy`.
- `rdy` and `rd_data` are registered outputs. They have no combinational path from bus inputs.
- `cs` must remain high from the `as` cycle through the `rdy` cycle; deassertion earlier is an abort, as described in Operation.

## Test plan
- Reset: hold `reset_`=0 for 3 cycles, then release and read registers 0..14 → each returns 32'h0 with `rdy` in cycle N+2 (`WAIT_CYCLES`=1); register 15 returns 32'h4C49_5400.
- Write/readback: write 32'hDEAD_BEEF to addr 3, then read addr 3 → write `rdy` at N+2; read `rd_data`=32'hDEAD_BEEF with `rdy`=1 for exactly one cycle; `rd_data`=0 on cycles either side.
- Wait states: with `WAIT_CYCLES`=0, 1 and 15, read addr 0 → `rdy` at N+1, N+2 and N+16 respectively; no `rdy` in any other cycle.
- Abort: start a write of 32'h1234_5678 to addr 5, and drop `cs` one cycle after `as` with `WAIT_CYCLES`=3 → no `rdy`; a later read of addr 5 returns 32'h0.
- Ignored strobe / RO register: pulse `as` again during WAIT, then write 32'hFFFF_FFFF to addr 15 → only one `rdy` per accepted request; addr 15 still reads 32'h4C49_5400.
- Async reset mid-read: assert `reset_`=0 during WAIT → `rdy` and `rd_data` go to 0 without waiting for a clock edge, and no `rdy` follows after release.
